// File: rtl/uart_rx_os16.sv
// uart_rx_os16: system-clock UART receiver, oversampled with 3-sample majority vote,
// optional parity, framing/parity/overrun flags and a valid/ack output handshake.
module uart_rx_os16 #(
    parameter int WORD_LENGHT = 8,
    parameter int FREQUENCY   = 50000000,
    parameter int BAUDRATE    = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter bit PARITY_EN   = 1'b0,
    parameter bit PARITY_ODD  = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Rx_in,
    input  logic                   Rx_ack,
    output logic [WORD_LENGHT-1:0] Rx_out,
    output logic                   new_Rx,
    output logic                   Rx_valid,
    output logic                   Rx_error,
    output logic                   parity_error,
    output logic                   Rx_overrun
);
    localparam int DIV = FREQUENCY / (BAUDRATE * OVERSAMPLE);
    localparam int CW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int KW  = WORD_LENGHT > 1 ? $clog2(WORD_LENGHT) : 1;
    localparam int H   = OVERSAMPLE / 2;
    localparam logic [CW-1:0] C_TOP = CW'(DIV - 1);
    localparam logic [SW-1:0] S_A   = SW'(H - 1);
    localparam logic [SW-1:0] S_B   = SW'(H);
    localparam logic [SW-1:0] S_C   = SW'(H + 1);
    localparam logic [SW-1:0] S_TOP = SW'(OVERSAMPLE - 1);
    localparam logic [KW-1:0] K_TOP = KW'(WORD_LENGHT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HI} state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync2_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SW-1:0]          s_q, s_d;
    logic [KW-1:0]          k_q, k_d;
    logic                   sa_q, sa_d, sb_q, sb_d;
    logic [WORD_LENGHT-1:0] data_q, data_d;
    logic                   fperr_q, fperr_d;
    logic [WORD_LENGHT-1:0] out_q, out_d;
    logic                   new_q, new_d, valid_q, valid_d, err_q, err_d;
    logic                   perr_q, perr_d, ovr_q, ovr_d;
    logic                   tick, rxs, maj, at_c, at_end, done;

    always_comb begin
        tick    = cnt_q == C_TOP;
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        rxs     = sync2_q;
        maj     = (sa_q & sb_q) | (sa_q & rxs) | (sb_q & rxs);
        at_c    = tick && s_q == S_C;
        at_end  = tick && s_q == S_TOP;
        state_d = state_q;
        s_d     = tick ? (s_q == S_TOP ? '0 : s_q + 1'b1) : s_q;
        k_d     = k_q;
        sa_d    = (tick && s_q == S_A) ? rxs : sa_q;
        sb_d    = (tick && s_q == S_B) ? rxs : sb_q;
        data_d  = data_q;
        fperr_d = fperr_q;
        done    = 1'b0;
        case (state_q)
            IDLE: if (tick && !rxs) begin
                state_d = START;
                s_d     = SW'(1);
            end
            START: if (at_c && maj) state_d = IDLE;
                   else if (at_end) begin
                       state_d = DATA;
                       k_d     = '0;
                   end
            DATA: begin
                if (at_c) data_d = {maj, data_q[WORD_LENGHT-1:1]};
                if (at_end) begin
                    k_d = k_q + 1'b1;
                    if (k_q == K_TOP) state_d = PARITY_EN ? PAR : STOP;
                end
            end
            PAR: begin
                if (at_c) fperr_d = ^data_q ^ maj ^ PARITY_ODD;
                if (at_end) state_d = STOP;
            end
            // Leave at mid-stop so a back-to-back start edge is never missed.
            STOP: if (at_c) begin
                done    = 1'b1;
                state_d = maj ? IDLE : WAIT_HI;
            end
            WAIT_HI: if (tick && rxs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        out_d   = done ? data_q : out_q;
        new_d   = done;
        err_d   = done ? ~maj : err_q;
        perr_d  = done ? fperr_q : perr_q;
        ovr_d   = done ? valid_q & ~Rx_ack : ovr_q;
        valid_d = done | (valid_q & ~Rx_ack);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            s_q     <= '0;
            k_q     <= '0;
            sa_q    <= 1'b1;
            sb_q    <= 1'b1;
            data_q  <= '0;
            fperr_q <= 1'b0;
            out_q   <= '0;
            new_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= Rx_in;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            k_q     <= k_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            data_q  <= data_d;
            fperr_q <= fperr_d;
            out_q   <= out_d;
            new_q   <= new_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign Rx_out       = out_q;
    assign new_Rx       = new_q;
    assign Rx_valid     = valid_q;
    assign Rx_error     = err_q;
    assign parity_error = perr_q;
    assign Rx_overrun   = ovr_q;
endmodule
